// File: rtl/g02_pattern_stepper_pkg.sv
// Shared types and widths for the g02 pattern stepper.
package g02_pattern_stepper_pkg;

  localparam int STIM_W  = 4;
  localparam int TABLE_W = 16;

  localparam logic [TABLE_W-1:0] TABLE_FULL = {TABLE_W{1'b1}};

  // Stepping mode; the encoding doubles as the auto_mode output bit.
  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

endpackage

// File: rtl/btn_debounce_pulse.sv
// Raw push-button conditioning: 2-FF synchronizer, debounce counter that
// accepts a new level only after DEBOUNCE_CYCLES consecutive samples of it,
// and a one-cycle pulse on every accepted released->pressed change.
module btn_debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  // Count consecutive samples that disagree with the accepted level; any
  // agreeing sample restarts the count, so short glitches are discarded.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    pulse_d = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        pulse_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchronizer and debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/g02_pattern_stepper.sv
// Stimulus stage for the g02 combinational exercises: steps a_out through
// 0..15 (manual button or fixed-rate auto), samples z_in one cycle after each
// change of a_out and assembles the 16-entry truth table.
// The mode FSM state is visible directly on auto_mode.
module g02_pattern_stepper
  import g02_pattern_stepper_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int AUTO_PERIOD     = 6000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_step,
  input  logic               btn_mode,
  input  logic               z_in,
  output logic [STIM_W-1:0]  a_out,
  output logic               auto_mode,
  output logic [TABLE_W-1:0] table_out,
  output logic               table_valid
);

  localparam int TICK_W = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(AUTO_PERIOD - 1);

  logic step_p;
  logic mode_p;

  mode_e              state_q, state_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [STIM_W-1:0]  a_q, a_d;
  logic               pend_q, pend_d;
  logic [TABLE_W-1:0] table_q, table_d;
  logic [TABLE_W-1:0] mask_q, mask_d;
  logic               valid_q, valid_d;

  logic tick_term;
  logic step_evt;
  logic step_go;

  btn_debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn_step),
    .pulse_o (step_p)
  );

  btn_debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn_mode),
    .pulse_o (mode_p)
  );

  // A mode toggle in the same cycle as a step event suppresses the step.
  assign tick_term = (state_q == MODE_AUTO) && (tick_q == TICK_LAST);
  assign step_evt  = (state_q == MODE_MANUAL) ? step_p : tick_term;
  assign step_go   = step_evt && !mode_p;

  // Mode FSM next state: each debounced mode press toggles MANUAL/AUTO.
  always_comb begin
    state_d = state_q;
    if (mode_p) begin
      state_d = (state_q == MODE_MANUAL) ? MODE_AUTO : MODE_MANUAL;
    end
  end

  // Tick counter, stimulus counter and truth-table capture next state.
  always_comb begin
    tick_d  = '0;
    a_d     = a_q;
    pend_d  = pend_q;
    table_d = table_q;
    mask_d  = mask_q;
    valid_d = (mask_q == TABLE_FULL);

    if (!mode_p && (state_q == MODE_AUTO) && !tick_term) begin
      tick_d = tick_q + TICK_W'(1);
    end

    // A pending capture always uses the current (pre-increment) a_q.
    if (pend_q) begin
      table_d[a_q] = z_in;
      mask_d[a_q]  = 1'b1;
      pend_d       = 1'b0;
    end

    if (step_go) begin
      a_d    = a_q + STIM_W'(1);
      pend_d = 1'b1;
    end

    // A mode transition restarts collection but keeps the old table visible.
    if (mode_p) begin
      mask_d  = '0;
      valid_d = 1'b0;
    end
  end

  // State registers; entry 0 is captured on the first clock after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MODE_MANUAL;
      tick_q  <= '0;
      a_q     <= '0;
      pend_q  <= 1'b1;
      table_q <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      a_q     <= a_d;
      pend_q  <= pend_d;
      table_q <= table_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
    end
  end

  assign a_out       = a_q;
  assign auto_mode   = (state_q == MODE_AUTO);
  assign table_out   = table_q;
  assign table_valid = valid_q;

endmodule

// File: tb/tb_g02_pattern_stepper.sv
// Bench for g02_pattern_stepper with DEBOUNCE_CYCLES=4, AUTO_PERIOD=8 and a
// downstream block modelled as z = ^a.
module tb_g02_pattern_stepper;

  logic        clk;
  logic        rst_n;
  logic        btn_step;
  logic        btn_mode;
  logic        z_in;
  logic [3:0]  a_out;
  logic        auto_mode;
  logic [15:0] table_out;
  logic        table_valid;

  int checks;
  int failures;

  g02_pattern_stepper #(
    .DEBOUNCE_CYCLES(4),
    .AUTO_PERIOD    (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_step    (btn_step),
    .btn_mode    (btn_mode),
    .z_in        (z_in),
    .a_out       (a_out),
    .auto_mode   (auto_mode),
    .table_out   (table_out),
    .table_valid (table_valid)
  );

  // Downstream combinational block: odd parity of a.
  assign z_in = ^a_out;

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, got, exp);
    end
  endtask

  // Driver: hold the selected buttons high for 'hold' clocks, starting at a negedge.
  task automatic press(input logic s, input logic m, input int hold);
    btn_step = s;
    btn_mode = m;
    repeat (hold) @(negedge clk);
    btn_step = 1'b0;
    btn_mode = 1'b0;
  endtask

  // Bounded wait for auto_mode to reach a value; an expired budget fails.
  task automatic wait_mode(input logic exp, input int budget);
    int n;
    n = 0;
    while (auto_mode !== exp && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("mode_wait", {15'd0, auto_mode}, {15'd0, exp});
  endtask

  typedef struct {
    int          hold;
    logic [3:0]  exp_a;
    logic [15:0] exp_table;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [3:0] a0;
    logic [3:0] a_start;
    checks   = 0;
    failures = 0;
    btn_step = 1'b0;
    btn_mode = 1'b0;

    // Manual press vectors: holds of 3 clocks or fewer must be rejected,
    // 4 clocks is the shortest accepted press.
    vecs[0] = '{hold: 2,  exp_a: 4'd0, exp_table: 16'h0000};
    vecs[1] = '{hold: 3,  exp_a: 4'd0, exp_table: 16'h0000};
    vecs[2] = '{hold: 10, exp_a: 4'd1, exp_table: 16'h0002};
    vecs[3] = '{hold: 4,  exp_a: 4'd2, exp_table: 16'h0006};
    vecs[4] = '{hold: 1,  exp_a: 4'd2, exp_table: 16'h0006};
    vecs[5] = '{hold: 7,  exp_a: 4'd3, exp_table: 16'h0006};

    // Asynchronous reset values without any clock edge.
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check("rst_a", {12'd0, a_out}, 16'h0000);
    check("rst_auto", {15'd0, auto_mode}, 16'h0000);
    check("rst_table", table_out, 16'h0000);
    check("rst_valid", {15'd0, table_valid}, 16'h0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: entry 0 captured (z=0), not yet valid.
    repeat (10) @(negedge clk);
    check("idle_a", {12'd0, a_out}, 16'h0000);
    check("idle_table", table_out, 16'h0000);
    check("idle_valid", {15'd0, table_valid}, 16'h0000);

    // Manual stepping vectors, including bounce-length presses.
    for (int i = 0; i < 6; i++) begin
      press(1'b1, 1'b0, vecs[i].hold);
      repeat (14) @(negedge clk);
      check($sformatf("man%0d_a", i), {12'd0, a_out}, {12'd0, vecs[i].exp_a});
      check($sformatf("man%0d_table", i), table_out, vecs[i].exp_table);
      check($sformatf("man%0d_auto", i), {15'd0, auto_mode}, 16'h0000);
    end

    // AUTO sweep: 16 steps of 8 clocks bring a back to 3 with a full table.
    press(1'b0, 1'b1, 6);
    wait_mode(1'b1, 30);
    check("auto_entry_valid", {15'd0, table_valid}, 16'h0000);
    check("auto_entry_table", table_out, 16'h0006);
    check("auto_entry_a", {12'd0, a_out}, 16'h0003);
    repeat (132) @(negedge clk);
    check("auto_sweep_a", {12'd0, a_out}, 16'h0003);
    check("auto_sweep_table", table_out, 16'h6996);
    check("auto_sweep_valid", {15'd0, table_valid}, 16'h0001);

    // AUTO ignores the step button: only the 8-clock tick advances a.
    a0 = a_out;
    begin
      int n;
      n = 0;
      while (a_out === a0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("auto_tick_seen", {15'd0, (a_out !== a0)}, 16'h0001);
    end
    a0 = a_out;
    btn_step = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i < 8) check($sformatf("auto_hold%0d", i), {12'd0, a_out}, {12'd0, a0});
      else       check("auto_tick_step", {12'd0, a_out}, {12'd0, a0 + 4'd1});
    end
    repeat (3) @(negedge clk);
    btn_step = 1'b0;
    repeat (12) @(negedge clk);
    check("auto_valid_kept", {15'd0, table_valid}, 16'h0001);

    // Back to MANUAL: valid clears, table retained.
    press(1'b0, 1'b1, 6);
    wait_mode(1'b0, 30);
    check("man_entry_valid", {15'd0, table_valid}, 16'h0000);
    check("man_entry_table", table_out, 16'h6996);
    repeat (10) @(negedge clk);

    // 16 manual steps refill the table from an arbitrary start.
    a_start = a_out;
    for (int i = 0; i < 16; i++) begin
      press(1'b1, 1'b0, 6);
      repeat (12) @(negedge clk);
      check($sformatf("sweep%0d_a", i), {12'd0, a_out}, {12'd0, a_start + 4'(i + 1)});
    end
    check("man_sweep_table", table_out, 16'h6996);
    check("man_sweep_valid", {15'd0, table_valid}, 16'h0001);

    // Simultaneous mode and step pulses: mode wins, a unchanged.
    press(1'b1, 1'b1, 6);
    wait_mode(1'b1, 30);
    check("simul_a", {12'd0, a_out}, {12'd0, a_start});
    check("simul_valid", {15'd0, table_valid}, 16'h0000);
    check("simul_table", table_out, 16'h6996);

    // Asynchronous reset between clock edges while in AUTO.
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_a", {12'd0, a_out}, 16'h0000);
    check("arst_auto", {15'd0, auto_mode}, 16'h0000);
    check("arst_table", table_out, 16'h0000);
    check("arst_valid", {15'd0, table_valid}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_a", {12'd0, a_out}, 16'h0000);
    check("post_auto", {15'd0, auto_mode}, 16'h0000);
    check("post_valid", {15'd0, table_valid}, 16'h0000);

    // Final report.
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
